// File: rtl/systolic_array_ctrl.sv
// rtl/systolic_array_ctrl.sv - weight-stationary NxN systolic array tile sequencer
// Optional feature: SA_WEIGHT_REUSE_EN lets a tile skip the weight load and keep the PE weights.
module systolic_array_ctrl #(
   parameter int N     = 8,
   parameter int M_MAX = 256,
   parameter int AW_W  = $clog2(N),
   parameter int AW_A  = $clog2(M_MAX)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [AW_A:0]   cfg_num_vecs,
   input  logic            cfg_reuse_wt,
   output logic            wt_rd_en,
   output logic [AW_W-1:0] wt_rd_addr,
   output logic            act_rd_en,
   output logic [AW_A-1:0] act_rd_addr,
   output logic [N-1:0]    row_wt_en,
   output logic [N-1:0]    row_valid,
   output logic [N-1:0]    col_out_valid,
   output logic            busy,
   output logic            done,
   output logic            cfg_err
);

   typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

   localparam logic [AW_W:0]   K_LAST = (AW_W+1)'(N);
   localparam logic [AW_W:0]   ONE_W  = (AW_W+1)'(1);
   localparam logic [AW_A:0]   ONE_M  = (AW_A+1)'(1);
   localparam logic [AW_A-1:0] ONE_A  = AW_A'(1);
   localparam logic [N-1:0]    ONE_N  = N'(1);

   state_t          state;
   logic [AW_W:0]   wcnt;
   logic [AW_W:0]   wnext;
   logic [AW_A-1:0] m_last;
   logic [AW_A:0]   m_dec;
   logic            base_vld;
   logic [2*N-1:1]  dly;
   logic            cfg_ok;
   logic            reuse;

`ifdef SA_WEIGHT_REUSE_EN
   assign reuse = cfg_reuse_wt;
`else
   assign reuse = 1'b0 & cfg_reuse_wt;
`endif

   assign cfg_ok = (cfg_num_vecs != '0) && (32'(cfg_num_vecs) <= 32'(M_MAX));
   assign m_dec  = cfg_num_vecs - ONE_M;
   assign wnext  = wcnt + ONE_W;

   // dly[d] is base_vld delayed d cycles; rows tap the front, columns the back
   assign row_valid     = {dly[N-1:1], base_vld};
   assign col_out_valid = dly[2*N-1:N];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         wcnt        <= '0;
         m_last      <= '0;
         base_vld    <= 1'b0;
         dly         <= '0;
         wt_rd_en    <= 1'b0;
         wt_rd_addr  <= '0;
         act_rd_en   <= 1'b0;
         act_rd_addr <= '0;
         row_wt_en   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         base_vld <= act_rd_en;
         dly      <= {dly[2*N-2:1], base_vld};
         done     <= 1'b0;
         cfg_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (!cfg_ok) begin
                     cfg_err <= 1'b1;
                  end else begin
                     m_last <= m_dec[AW_A-1:0];
                     busy   <= 1'b1;
                     if (reuse) begin
                        state       <= STREAM;
                        act_rd_en   <= 1'b1;
                        act_rd_addr <= '0;
                     end else begin
                        state      <= LOAD_W;
                        wcnt       <= '0;
                        wt_rd_en   <= 1'b1;
                        wt_rd_addr <= '0;
                     end
                  end
               end
            end
            LOAD_W: begin
               if (wcnt == K_LAST) begin
                  row_wt_en   <= '0;
                  state       <= STREAM;
                  act_rd_en   <= 1'b1;
                  act_rd_addr <= '0;
               end else begin
                  // row enable trails the read strobe by one cycle to meet the returned data
                  wcnt       <= wnext;
                  row_wt_en  <= ONE_N << wcnt;
                  wt_rd_en   <= (wnext != K_LAST);
                  wt_rd_addr <= (wnext != K_LAST) ? wnext[AW_W-1:0] : '0;
               end
            end
            STREAM: begin
               if (act_rd_addr == m_last) begin
                  act_rd_en   <= 1'b0;
                  act_rd_addr <= '0;
                  state       <= DRAIN;
               end else begin
                  act_rd_addr <= act_rd_addr + ONE_A;
               end
            end
            DRAIN: begin
               // act_rd_en is already low here, so next cycle the pipes are empty
               if (!base_vld && (dly[2*N-2:1] == '0)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
